// File: rtl/mmu_walker.sv
// Sv32 two-level page-table walker: fetches the L1 PTE, then the L0 PTE when the L1 entry is a pointer.
// Completes one cycle after the final PTE response; an abort drains any outstanding read without a pulse.
module mmu_walker #(
    parameter int ENABLE_AD_FAULT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic [31:0] virtual_address,
    input  logic        execute,
    input  logic        rnw,
    input  logic [21:0] satp_ppn,
    input  logic        mxr,
    input  logic        sum,
    input  logic [1:0]  privilege,
    input  logic        abort,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        write_entry,
    output logic        is_fault,
    output logic [19:0] upper_physical_address,
    output logic        superpage,
    output logic [7:0]  perms,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DRAIN, DONE, FAULT
    } state_t;

    state_t      state, state_next;
    logic [9:0]  vpn0;
    logic        execute_q, rnw_q, mxr_q, sum_q;
    logic [1:0]  privilege_q;

    logic pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    logic is_load, is_store;
    logic pte_bad, pte_pointer, perm_fault, misaligned;
    logic unused_bits;

    assign pte_v = mem_rdata[0];
    assign pte_r = mem_rdata[1];
    assign pte_w = mem_rdata[2];
    assign pte_x = mem_rdata[3];
    assign pte_u = mem_rdata[4];
    assign pte_a = mem_rdata[6];
    assign pte_d = mem_rdata[7];

    assign is_load  = ~execute_q & rnw_q;
    assign is_store = ~execute_q & ~rnw_q;

    assign pte_bad     = ~pte_v | (~pte_r & pte_w) | (|mem_rdata[31:30]);
    assign pte_pointer = ~pte_r & ~pte_w & ~pte_x;
    assign misaligned  = |mem_rdata[19:10];

    // Only meaningful for a leaf; pointer and malformed PTEs are filtered first.
    assign perm_fault = (execute_q & ~pte_x)
                      | (is_load & ~(pte_r | (pte_x & mxr_q)))
                      | (is_store & ~(pte_r & pte_w))
                      | ((privilege_q == 2'd0) & ~pte_u)
                      | ((privilege_q == 2'd1) & pte_u & (execute_q | ~sum_q))
                      | ((ENABLE_AD_FAULT != 0) & (~pte_a | (is_store & ~pte_d)));

    assign unused_bits = ^{satp_ppn[21:20], virtual_address[11:0], mem_rdata[9:8]};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (request) state_next = L1_REQ;
            L1_REQ: begin
                if (abort)        state_next = mem_ack ? DRAIN : IDLE;
                else if (mem_ack) state_next = L1_WAIT;
            end
            L1_WAIT: begin
                // A response arriving with the abort closes the read, so nothing is left to drain.
                if (abort)                   state_next = mem_rvalid ? IDLE : DRAIN;
                else if (mem_rvalid) begin
                    if (pte_bad)             state_next = FAULT;
                    else if (pte_pointer)    state_next = L0_REQ;
                    else if (misaligned | perm_fault) state_next = FAULT;
                    else                     state_next = DONE;
                end
            end
            L0_REQ: begin
                if (abort)        state_next = mem_ack ? DRAIN : IDLE;
                else if (mem_ack) state_next = L0_WAIT;
            end
            L0_WAIT: begin
                if (abort)           state_next = mem_rvalid ? IDLE : DRAIN;
                else if (mem_rvalid) state_next = (pte_bad | pte_pointer | perm_fault) ? FAULT : DONE;
            end
            DRAIN:   if (mem_rvalid) state_next = IDLE;
            DONE:    state_next = IDLE;
            FAULT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= IDLE;
            mem_addr               <= '0;
            vpn0                   <= '0;
            execute_q              <= 1'b0;
            rnw_q                  <= 1'b0;
            mxr_q                  <= 1'b0;
            sum_q                  <= 1'b0;
            privilege_q            <= 2'd0;
            upper_physical_address <= '0;
            superpage              <= 1'b0;
            perms                  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && request) begin
                mem_addr    <= {satp_ppn[19:0], virtual_address[31:22], 2'b00};
                vpn0        <= virtual_address[21:12];
                execute_q   <= execute;
                rnw_q       <= rnw;
                mxr_q       <= mxr;
                sum_q       <= sum;
                privilege_q <= privilege;
            end
            if (state == L1_WAIT && state_next == L0_REQ)
                mem_addr <= {mem_rdata[29:10], vpn0, 2'b00};
            if (state_next == DONE) begin
                superpage              <= (state == L1_WAIT);
                upper_physical_address <= (state == L1_WAIT) ? {mem_rdata[29:20], vpn0}
                                                             : mem_rdata[29:10];
                perms                  <= mem_rdata[7:0];
            end
        end
    end

    assign mem_request = (state == L1_REQ) | (state == L0_REQ);
    assign busy        = (state != IDLE);
    assign write_entry = (state == DONE);
    assign is_fault    = (state == FAULT);

endmodule

// File: tb/tb_mmu_walker.sv
// Directed bench for mmu_walker: walks, faults, aborts, back-pressure and reset mid-walk.
module tb_mmu_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic [31:0] virtual_address;
    logic        execute;
    logic        rnw;
    logic [21:0] satp_ppn;
    logic        mxr;
    logic        sum;
    logic [1:0]  privilege;
    logic        abort;
    logic        mem_request;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        write_entry;
    logic        is_fault;
    logic [19:0] upper_physical_address;
    logic        superpage;
    logic [7:0]  perms;
    logic        busy;

    int checks = 0;
    int failures = 0;

    mmu_walker dut (
        .clk(clk), .rst(rst), .request(request), .virtual_address(virtual_address),
        .execute(execute), .rnw(rnw), .satp_ppn(satp_ppn), .mxr(mxr), .sum(sum),
        .privilege(privilege), .abort(abort), .mem_request(mem_request), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .write_entry(write_entry), .is_fault(is_fault),
        .upper_physical_address(upper_physical_address), .superpage(superpage),
        .perms(perms), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Request for one cycle; mem_request must not respond in the same cycle.
    task automatic issue(input string tag, input logic [31:0] va, input logic ex, input logic rd);
        virtual_address = va;
        execute         = ex;
        rnw             = rd;
        request         = 1'b1;
        #1;
        chk($sformatf("%s_no_comb_req", tag), 32'(mem_request), 32'd0);
        step();
        request = 1'b0;
    endtask

    // One PTE read: address held for delay+1 cycles, ack on the last, response the cycle after.
    task automatic rd_pte(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int delay);
        for (int i = 0; i <= delay; i++) begin
            chk($sformatf("%s_req%0d", tag, i), 32'(mem_request), 32'd1);
            chk($sformatf("%s_addr%0d", tag, i), mem_addr, addr);
            request = (delay > 0) && (i == 2);
            mem_ack = (i == delay);
            step();
        end
        request    = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic expect_done(input string tag, input logic [19:0] upa, input logic sp,
                               input logic [7:0] pm);
        chk($sformatf("%s_we", tag), 32'(write_entry), 32'd1);
        chk($sformatf("%s_flt", tag), 32'(is_fault), 32'd0);
        chk($sformatf("%s_upa", tag), 32'(upper_physical_address), 32'(upa));
        chk($sformatf("%s_sp", tag), 32'(superpage), 32'(sp));
        chk($sformatf("%s_perms", tag), 32'(perms), 32'(pm));
        chk($sformatf("%s_memreq", tag), 32'(mem_request), 32'd0);
        step();
        chk($sformatf("%s_we_end", tag), 32'(write_entry), 32'd0);
        chk($sformatf("%s_idle", tag), 32'(busy), 32'd0);
    endtask

    task automatic expect_fault(input string tag);
        chk($sformatf("%s_flt", tag), 32'(is_fault), 32'd1);
        chk($sformatf("%s_we", tag), 32'(write_entry), 32'd0);
        step();
        chk($sformatf("%s_flt_end", tag), 32'(is_fault), 32'd0);
        chk($sformatf("%s_we_end", tag), 32'(write_entry), 32'd0);
        chk($sformatf("%s_idle", tag), 32'(busy), 32'd0);
    endtask

    task automatic expect_quiet(input string tag, input logic bsy);
        chk($sformatf("%s_busy", tag), 32'(busy), 32'(bsy));
        chk($sformatf("%s_we", tag), 32'(write_entry), 32'd0);
        chk($sformatf("%s_flt", tag), 32'(is_fault), 32'd0);
    endtask

    initial begin
        rst = 1'b1; request = 1'b0; virtual_address = '0; execute = 1'b0; rnw = 1'b1;
        satp_ppn = '0; mxr = 1'b0; sum = 1'b0; privilege = 2'd1; abort = 1'b0;
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) step();
        chk("rst_memreq", 32'(mem_request), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_we", 32'(write_entry), 32'd0);
        chk("rst_flt", 32'(is_fault), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sp", 32'(superpage), 32'd0);
        chk("rst_upa", 32'(upper_physical_address), 32'd0);
        chk("rst_perms", 32'(perms), 32'd0);
        rst = 1'b0;
        satp_ppn = 22'h00100;
        step();

        // 4 KiB walk: L1 pointer to PPN 0x00020, leaf PPN 0x12345.
        issue("t4k", 32'h40001234, 1'b0, 1'b1);
        rd_pte("t4k_l1", 32'h00100400, 32'h00008001, 0);
        rd_pte("t4k_l0", 32'h00020004, 32'h048D14CF, 0);
        expect_done("t4k", 20'h12345, 1'b0, 8'hCF);

        // Superpage leaf at level 1.
        issue("tsp", 32'h40001234, 1'b0, 1'b1);
        rd_pte("tsp_l1", 32'h00100400, 32'h001000CF, 0);
        expect_done("tsp", 20'h00401, 1'b1, 8'hCF);

        // Misaligned superpage.
        issue("tmis", 32'h40001234, 1'b0, 1'b1);
        rd_pte("tmis_l1", 32'h00100400, 32'h001004CF, 0);
        expect_fault("tmis");

        // Execute on a non-executable leaf.
        issue("tnx", 32'h40001234, 1'b1, 1'b1);
        rd_pte("tnx_l1", 32'h00100400, 32'h00008001, 0);
        rd_pte("tnx_l0", 32'h00020004, 32'h048D14C7, 0);
        expect_fault("tnx");

        // Store to a page with D=0.
        issue("tnd", 32'h40001234, 1'b0, 1'b0);
        rd_pte("tnd_l1", 32'h00100400, 32'h00008001, 0);
        rd_pte("tnd_l0", 32'h00020004, 32'h048D144F, 0);
        expect_fault("tnd");

        // User-mode access to a supervisor page.
        privilege = 2'd0;
        issue("tusr", 32'h40001234, 1'b0, 1'b1);
        privilege = 2'd1;
        rd_pte("tusr_l1", 32'h00100400, 32'h001000CF, 0);
        expect_fault("tusr");

        // Pointer at level 0.
        issue("tptr0", 32'h40001234, 1'b0, 1'b1);
        rd_pte("tptr0_l1", 32'h00100400, 32'h00008001, 0);
        rd_pte("tptr0_l0", 32'h00020004, 32'h00008001, 0);
        expect_fault("tptr0");

        // Abort in L1_WAIT; the response two cycles later is drained silently.
        issue("tab", 32'h40001234, 1'b0, 1'b1);
        chk("tab_addr", mem_addr, 32'h00100400);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        abort   = 1'b1;
        step();
        abort = 1'b0;
        expect_quiet("tab_drain0", 1'b1);
        chk("tab_drain_memreq", 32'(mem_request), 32'd0);
        step();
        expect_quiet("tab_drain1", 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h001000CF;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        expect_quiet("tab_idle", 1'b0);
        step();
        expect_quiet("tab_after", 1'b0);
        issue("tab2", 32'h40001234, 1'b0, 1'b1);
        rd_pte("tab2_l1", 32'h00100400, 32'h001000CF, 0);
        expect_done("tab2", 20'h00401, 1'b1, 8'hCF);

        // Abort in L1_REQ without an ack returns straight to IDLE.
        issue("tabr", 32'h40001234, 1'b0, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        expect_quiet("tabr", 1'b0);

        // Back-pressure: ack after 5 cycles, request pulse mid-walk ignored.
        issue("tbp", 32'h40001234, 1'b0, 1'b1);
        rd_pte("tbp_l1", 32'h00100400, 32'h00008001, 5);
        rd_pte("tbp_l0", 32'h00020004, 32'h048D14CF, 0);
        expect_done("tbp", 20'h12345, 1'b0, 8'hCF);
        step();
        chk("tbp_not_queued", 32'(busy), 32'd0);

        // Reset mid-walk; the late response must be ignored.
        issue("trst", 32'h40001234, 1'b0, 1'b1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        expect_quiet("trst_reset", 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h001000CF;
        step();
        mem_rvalid = 1'b0;
        expect_quiet("trst_late", 1'b0);
        chk("trst_memreq", 32'(mem_request), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
